// File: rtl/s86_bus_pkg.sv
// Shared S86 system-bus types and constants.
package s86_bus_pkg;

    localparam int unsigned ADR_W = 19;
    localparam int unsigned DAT_W = 16;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 8;

    localparam logic [DAT_W-1:0] ERR_DATA_DEF = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    // Request payload a master presents on the shared bus.
    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
        logic             we;
        logic             tga;
    } wb_req_t;

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Two-master / one-slave Wishbone bundle seen by the arbiter.
interface wb_bus_arbiter_if;
    import s86_bus_pkg::*;

    logic [ADR_W-1:0] m0_adr_i;
    logic [DAT_W-1:0] m0_dat_i;
    logic [SEL_W-1:0] m0_sel_i;
    logic             m0_we_i;
    logic             m0_tga_i;
    logic             m0_stb_i;
    logic             m0_cyc_i;
    logic             m0_ack_o;

    logic [ADR_W-1:0] m1_adr_i;
    logic [DAT_W-1:0] m1_dat_i;
    logic [SEL_W-1:0] m1_sel_i;
    logic             m1_we_i;
    logic             m1_tga_i;
    logic             m1_stb_i;
    logic             m1_cyc_i;
    logic             m1_ack_o;

    logic [DAT_W-1:0] m_dat_o;

    logic [ADR_W-1:0] s_adr_o;
    logic [DAT_W-1:0] s_dat_o;
    logic [SEL_W-1:0] s_sel_o;
    logic             s_we_o;
    logic             s_tga_o;
    logic             s_stb_o;
    logic             s_cyc_o;
    logic [DAT_W-1:0] s_dat_i;
    logic             s_ack_i;

    logic [1:0]       gnt_o;
    logic             to_err_o;

    // Arbiter side: slave to both masters, master toward the slave bus.
    modport slave (
        input  m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_tga_i, m0_stb_i, m0_cyc_i,
        input  m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_tga_i, m1_stb_i, m1_cyc_i,
        output m0_ack_o, m1_ack_o, m_dat_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_tga_o, s_stb_o, s_cyc_o,
        input  s_dat_i, s_ack_i,
        output gnt_o, to_err_o
    );

    // Environment side: drives masters and slave response.
    modport master (
        output m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_tga_i, m0_stb_i, m0_cyc_i,
        output m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_tga_i, m1_stb_i, m1_cyc_i,
        input  m0_ack_o, m1_ack_o, m_dat_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_tga_o, s_stb_o, s_cyc_o,
        output s_dat_i, s_ack_i,
        input  gnt_o, to_err_o
    );

endinterface

// File: rtl/wb_ack_watchdog.sv
// Counts unacknowledged strobe cycles and forces termination of a hung slave cycle.
module wb_ack_watchdog
    import s86_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic stb_act,    // owner strobe while bus is granted
    input  logic ack,        // slave ack
    input  logic state_chg,  // arbiter changes state at the next edge
    output logic forced_c,   // terminate the current cycle now
    output logic to_err      // registered pulse after a forced termination
);

    logic [CNT_W-1:0] cnt_q;

    // Terminate when the strobe has waited TIMEOUT-1 cycles already.
    always_comb begin
        forced_c = stb_act && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    // Wait counter and error pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            to_err <= 1'b0;
        end else begin
            to_err <= forced_c;
            if (state_chg || !stb_act || ack || forced_c) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter with ack watchdog for the S86 system bus.
module wb_bus_arbiter
    import s86_bus_pkg::*;
#(
    parameter int unsigned      TIMEOUT  = 16,
    parameter logic [DAT_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    wb_bus_arbiter_if.slave  bus
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;    // last owner; 1 after reset so master 0 wins first tie

    wb_req_t    m0_req, m1_req, own_req;
    logic       own0, own1, own_cyc, own_stb;
    logic       forced_c, to_err, state_chg;

    assign m0_req = {bus.m0_adr_i, bus.m0_dat_i, bus.m0_sel_i, bus.m0_we_i, bus.m0_tga_i};
    assign m1_req = {bus.m1_adr_i, bus.m1_dat_i, bus.m1_sel_i, bus.m1_we_i, bus.m1_tga_i};

    // Ownership is masked during reset so the bus releases in the reset cycle itself.
    assign own0      = (state_q == ST_OWN0) && !wb_rst_i;
    assign own1      = (state_q == ST_OWN1) && !wb_rst_i;
    assign own_req   = own1 ? m1_req : m0_req;
    assign own_cyc   = (own0 && bus.m0_cyc_i) || (own1 && bus.m1_cyc_i);
    assign own_stb   = (own0 && bus.m0_stb_i) || (own1 && bus.m1_stb_i);
    assign state_chg = (state_d != state_q);

    // State and last-owner registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state: round-robin grant from IDLE, hold while owner keeps cyc.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (bus.m0_cyc_i) begin
                    state_d = ST_OWN0;
                end else if (bus.m1_cyc_i) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!bus.m0_cyc_i) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b0;
                end
            end
            ST_OWN1: begin
                if (!bus.m1_cyc_i) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output muxes: route owner to slave bus and steer ack back to owner only.
    always_comb begin
        bus.s_adr_o  = '0;
        bus.s_dat_o  = '0;
        bus.s_sel_o  = '0;
        bus.s_we_o   = 1'b0;
        bus.s_tga_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_cyc_o  = 1'b0;
        bus.m0_ack_o = 1'b0;
        bus.m1_ack_o = 1'b0;
        bus.gnt_o    = {own1, own0};
        bus.m_dat_o  = forced_c ? ERR_DATA : bus.s_dat_i;
        if (own0 || own1) begin
            bus.s_adr_o  = own_req.adr;
            bus.s_dat_o  = own_req.dat;
            bus.s_sel_o  = own_req.sel;
            bus.s_we_o   = own_req.we;
            bus.s_tga_o  = own_req.tga;
            bus.s_stb_o  = own_stb && !forced_c;
            bus.s_cyc_o  = own_cyc && !forced_c;
            bus.m0_ack_o = own0 && ((bus.s_ack_i && own_stb) || forced_c);
            bus.m1_ack_o = own1 && ((bus.s_ack_i && own_stb) || forced_c);
        end
    end

    assign bus.to_err_o = to_err;

    wb_ack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .stb_act   (own_stb),
        .ack       (bus.s_ack_i),
        .state_chg (state_chg),
        .forced_c  (forced_c),
        .to_err    (to_err)
    );

endmodule
